// File: rtl/broadcast_pkg.sv
// -----------------------------------------------------------------------------
// broadcast_pkg
// Shared types for the broadcast scheduler:
//   sched_state_t  - scheduler state (RUN accepts issues, DRAIN waits for a
//                    barrier message to leave the tree)
//   trk_entry_t    - one slot of the completion tracker {valid, id}
//   calc_id_width  - requester-id width for a given requester count
// -----------------------------------------------------------------------------
package broadcast_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_t;

    // Tracker ids are stored at a fixed maximum width so the struct can live
    // here; the scheduler only uses the low ID_WIDTH bits.
    localparam int MAX_ID_WIDTH = 8;

    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
    } trk_entry_t;

    function automatic int calc_id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search: finds the first asserted request
// at or after the pointer, wrapping modulo REQUESTERS.
//   req_i    in  REQUESTERS  request vector
//   ptr_i    in  IDW         search start position
//   idx_o    out IDW         selected requester (0 when none found)
//   found_o  out 1           at least one request asserted
// -----------------------------------------------------------------------------
module rr_arbiter
    import broadcast_pkg::*;
#(
    parameter int  REQUESTERS = 4,
    localparam int IDW        = calc_id_width(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req_i,
    input  logic [IDW-1:0]        ptr_i,
    output logic [IDW-1:0]        idx_o,
    output logic                  found_o
);

    logic [IDW-1:0] pos;

    // Walk offsets from the farthest down to zero so the nearest request to
    // the pointer is the last (winning) assignment.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            pos = IDW'((int'(ptr_i) + k) % REQUESTERS);
            if (req_i[pos]) begin
                idx_o   = pos;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/broadcast_scheduler.sv
// -----------------------------------------------------------------------------
// broadcast_scheduler
// Round-robin sharing of one broadcast path among REQUESTERS sources, with an
// in-order completion tracker matched to the tree latency and support for
// barrier (blocking) messages.
//   clk           in  1                         clock
//   reset         in  1                         async active-high reset
//   req_valid     in  REQUESTERS                per-requester request
//   req_message   in  MESSAGE_WIDTH*REQUESTERS  message i at [i*MW +: MW]
//   req_blocking  in  REQUESTERS                request is a barrier
//   req_ready     out REQUESTERS                one-hot grant (or zero)
//   out_valid     out 1                         message valid into the tree
//   out_message   out MESSAGE_WIDTH             message into the tree
//   done_valid    out 1                         completion pulse
//   done_id       out ID_WIDTH                  requester that completed
//   busy          out 1                         anything in flight or draining
// -----------------------------------------------------------------------------
module broadcast_scheduler
    import broadcast_pkg::*;
#(
    parameter int  MESSAGE_WIDTH = 16,
    parameter int  REQUESTERS    = 4,
    parameter int  TREE_LATENCY  = 2,
    localparam int ID_WIDTH      = calc_id_width(REQUESTERS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [REQUESTERS-1:0]               req_valid,
    input  logic [MESSAGE_WIDTH*REQUESTERS-1:0] req_message,
    input  logic [REQUESTERS-1:0]               req_blocking,
    output logic [REQUESTERS-1:0]               req_ready,
    output logic                                out_valid,
    output logic [MESSAGE_WIDTH-1:0]            out_message,
    output logic                                done_valid,
    output logic [ID_WIDTH-1:0]                 done_id,
    output logic                                busy
);

    localparam int DEPTH = TREE_LATENCY + 1;

    sched_state_t             state_q;
    logic [ID_WIDTH-1:0]      rr_q, rr_d;
    logic                     out_valid_q;
    logic [MESSAGE_WIDTH-1:0] out_message_q, out_message_d;
    trk_entry_t               trk_q [DEPTH];
    trk_entry_t               trk_d;
    trk_entry_t               done_q;

    logic [ID_WIDTH-1:0]      cand;
    logic                     found;
    logic                     cand_blocking;
    logic                     trk_busy;
    logic                     handshake;
    logic                     unused_id_bits;

    rr_arbiter #(
        .REQUESTERS (REQUESTERS)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .idx_o   (cand),
        .found_o (found)
    );

    // Occupancy of the shift stages only; the completion register is left
    // out so a barrier may issue in the same cycle the last message retires.
    always_comb begin
        trk_busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            trk_busy = trk_busy | trk_q[k].valid;
        end
    end

    // A stalled barrier candidate is not skipped: the pointer stays on it so
    // later requesters cannot overtake it.
    always_comb begin
        req_ready     = '0;
        cand_blocking = req_blocking[cand];
        if (found && (state_q == RUN) && (!cand_blocking || !trk_busy)) begin
            req_ready[cand] = 1'b1;
        end
    end

    assign handshake = |(req_ready & req_valid);

    always_comb begin
        rr_d          = rr_q;
        out_message_d = out_message_q;
        trk_d         = '0;
        if (handshake) begin
            rr_d          = (cand == ID_WIDTH'(REQUESTERS - 1)) ? '0 : cand + 1'b1;
            out_message_d = req_message[cand*MESSAGE_WIDTH +: MESSAGE_WIDTH];
            trk_d.valid   = 1'b1;
            trk_d.id      = MAX_ID_WIDTH'(cand);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            rr_q          <= '0;
            out_valid_q   <= 1'b0;
            out_message_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                trk_q[k] <= '0;
            end
            done_q        <= '0;
        end else begin
            rr_q          <= rr_d;
            out_valid_q   <= handshake;
            out_message_q <= out_message_d;
            trk_q[0]      <= trk_d;
            for (int k = 1; k < DEPTH; k++) begin
                trk_q[k] <= trk_q[k-1];
            end
            done_q        <= trk_q[DEPTH-1];
            case (state_q)
                RUN:     if (handshake && cand_blocking) state_q <= DRAIN;
                // While draining, the barrier is the only message in flight,
                // so any completion belongs to it.
                DRAIN:   if (done_q.valid) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign out_valid      = out_valid_q;
    assign out_message    = out_message_q;
    assign done_valid     = done_q.valid;
    assign done_id        = done_q.id[ID_WIDTH-1:0];
    // The completion stage still counts as in flight for busy.
    assign busy           = trk_busy | done_q.valid | out_valid_q | (state_q == DRAIN);
    assign unused_id_bits = ^done_q.id;

endmodule

// File: tb/tb_broadcast_scheduler.sv
// -----------------------------------------------------------------------------
// tb_broadcast_scheduler
// Main DUT: REQUESTERS=4, TREE_LATENCY=2, checked every cycle against an
// issue-history model. Second DUT: REQUESTERS=1, TREE_LATENCY=0, checked
// with literal expectations for back-to-back barriers.
// -----------------------------------------------------------------------------
module tb_broadcast_scheduler;

    localparam int MW   = 16;
    localparam int R    = 4;
    localparam int L    = 2;
    localparam int MAXC = 8192;

    logic           clk = 1'b0;
    logic           rst;
    logic [R-1:0]   req_valid, req_blocking, req_ready;
    logic [MW*R-1:0] req_message;
    logic           out_valid, done_valid, busy;
    logic [MW-1:0]  out_message;
    logic [1:0]     done_id;

    logic [0:0]     v1, b1, rdy1, did1;
    logic [MW-1:0]  m1, msg1;
    logic           ov1, dv1, busy1;

    always #5 clk = ~clk;

    broadcast_scheduler #(.MESSAGE_WIDTH(MW), .REQUESTERS(R), .TREE_LATENCY(L)) dut (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_message(req_message),
        .req_blocking(req_blocking), .req_ready(req_ready), .out_valid(out_valid),
        .out_message(out_message), .done_valid(done_valid), .done_id(done_id), .busy(busy)
    );

    broadcast_scheduler #(.MESSAGE_WIDTH(MW), .REQUESTERS(1), .TREE_LATENCY(0)) dut1 (
        .clk(clk), .reset(rst), .req_valid(v1), .req_message(m1),
        .req_blocking(b1), .req_ready(rdy1), .out_valid(ov1),
        .out_message(msg1), .done_valid(dv1), .done_id(did1), .busy(busy1)
    );

    // Issue history: one entry per cycle, indexed by cycle number.
    bit          h_iss [MAXC];
    int          h_id  [MAXC];
    bit          h_blk [MAXC];
    int          epoch  = 0;
    int          m_rr   = 0;
    logic [MW-1:0] m_last = '0;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // Literal expectations, filled by the stimulus and checked at their cycle.
    int          ex_cyc [512];
    int          ex_sel [512];
    logic [31:0] ex_val [512];
    string       ex_nm  [512];
    int          n_ex = 0;

    function automatic bit iss(input int c);
        if (c < 0 || c < epoch) return 1'b0;
        return h_iss[c];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual %0h required %0h", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        int            now, cand, did_e;
        bit            ov_e, dv_e, busy_e, drain_e, trk_e, found;
        logic [R-1:0]  rdy_e;
        logic [31:0]   act;
        now = cyc;
        if (rst) begin
            epoch  = now + 1;
            m_rr   = 0;
            m_last = '0;
        end
        // A message handshaken in cycle h is on the tree input in h+1, still
        // occupies the tracker through h+L+1 and completes in h+L+2.
        ov_e  = iss(now - 1);
        dv_e  = iss(now - L - 2);
        did_e = 0;
        if (dv_e) did_e = h_id[now-L-2];
        busy_e = 1'b0; drain_e = 1'b0; trk_e = 1'b0;
        for (int c = now - L - 2; c <= now - 1; c++) begin
            if (iss(c)) begin
                busy_e = 1'b1;
                if (h_blk[c]) drain_e = 1'b1;
                if (c >= now - L - 1) trk_e = 1'b1;
            end
        end
        found = 1'b0; cand = 0;
        for (int k = 0; k < R; k++) begin
            if (!found && req_valid[(m_rr + k) % R]) begin
                found = 1'b1;
                cand  = (m_rr + k) % R;
            end
        end
        rdy_e = '0;
        if (found && !drain_e && !(req_blocking[cand] && trk_e)) rdy_e[cand] = 1'b1;

        chk("req_ready",   32'(req_ready),   32'(rdy_e));
        chk("out_valid",   32'(out_valid),   32'(ov_e));
        chk("out_message", 32'(out_message), 32'(m_last));
        chk("done_valid",  32'(done_valid),  32'(dv_e));
        if (dv_e || rst) chk("done_id", 32'(done_id), 32'(did_e));
        chk("busy",        32'(busy),        32'(busy_e));

        for (int i = 0; i < n_ex; i++) begin
            if (ex_cyc[i] == now) begin
                case (ex_sel[i])
                    0:  act = 32'(req_ready);
                    1:  act = 32'(out_valid);
                    2:  act = 32'(out_message);
                    3:  act = 32'(done_valid);
                    4:  act = 32'(done_id);
                    5:  act = 32'(busy);
                    6:  act = 32'(rdy1);
                    7:  act = 32'(ov1);
                    8:  act = 32'(dv1);
                    9:  act = 32'(did1);
                    10: act = 32'(msg1);
                    default: act = 32'(busy1);
                endcase
                chk(ex_nm[i], act, ex_val[i]);
            end
        end

        h_iss[now] = 1'b0;
        if (!rst && (rdy_e != '0)) begin
            h_iss[now] = 1'b1;
            h_id[now]  = cand;
            h_blk[now] = req_blocking[cand];
            m_last     = req_message[cand*MW +: MW];
            m_rr       = (cand + 1) % R;
        end
        cyc = now + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int c);
        while (cyc < c) step();
    endtask

    task automatic ex(input int c, input int sel, input logic [31:0] v, input string nm);
        ex_cyc[n_ex] = c;
        ex_sel[n_ex] = sel;
        ex_val[n_ex] = v;
        ex_nm[n_ex]  = nm;
        n_ex++;
    endtask

    task automatic set_req(input int i, input bit v, input bit b, input logic [MW-1:0] m);
        req_valid[i]          = v;
        req_blocking[i]       = b;
        req_message[i*MW +: MW] = m;
    endtask

    task automatic clear_reqs();
        req_valid    = '0;
        req_blocking = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1'b1; req_valid = '0; req_blocking = '0; req_message = '0;
        v1 = '0; b1 = '0; m1 = '0;
        step(); step();
        rst = 1'b0;

        // Single requester
        b = cyc;
        ex(b+10, 0, 32'h4, "a_ready");
        ex(b+10, 5, 0, "a_busy_before");
        ex(b+11, 1, 1, "a_out_valid");
        ex(b+11, 2, 32'h00A5, "a_out_message");
        ex(b+12, 1, 0, "a_out_valid_pulse");
        for (int k = 11; k <= 14; k++) ex(b+k, 5, 1, "a_busy");
        ex(b+15, 5, 0, "a_busy_after");
        ex(b+13, 3, 0, "a_done_early");
        ex(b+14, 3, 1, "a_done_valid");
        ex(b+14, 4, 2, "a_done_id");
        ex(b+15, 3, 0, "a_done_pulse");
        go(b+10); set_req(2, 1'b1, 1'b0, 16'h00A5);
        step();   clear_reqs();
        go(b+18);

        // Fairness
        do_reset();
        b = cyc;
        for (int k = 0; k < 8; k++) begin
            ex(b+k,   0, 32'(1 << (k % 4)), "b_grant");
            ex(b+1+k, 1, 1, "b_out_valid");
            ex(b+1+k, 2, 32'h1000 + 32'(k % 4), "b_out_message");
            ex(b+4+k, 3, 1, "b_done_valid");
            ex(b+4+k, 4, 32'(k % 4), "b_done_id");
        end
        ex(b+9, 1, 0, "b_out_valid_end");
        for (int i = 0; i < R; i++) set_req(i, 1'b1, 1'b0, 16'h1000 + 16'(i));
        repeat (8) step();
        clear_reqs();
        go(b+14);

        // Barrier
        do_reset();
        b = cyc;
        ex(b, 0, 32'h1, "c_first_grant");
        for (int k = 1; k <= 3; k++) ex(b+k, 0, 0, "c_barrier_wait");
        ex(b+4, 0, 32'h2, "c_barrier_grant");
        ex(b+4, 3, 1, "c_first_done");
        ex(b+4, 4, 0, "c_first_done_id");
        ex(b+5, 1, 1, "c_barrier_out_valid");
        ex(b+5, 2, 32'hBEEF, "c_barrier_message");
        for (int k = 5; k <= 8; k++) ex(b+k, 0, 0, "c_drain_stall");
        ex(b+8, 3, 1, "c_barrier_done");
        ex(b+8, 4, 1, "c_barrier_done_id");
        ex(b+8, 5, 1, "c_busy_at_done");
        ex(b+9, 5, 0, "c_busy_after_done");
        ex(b+9, 0, 32'h4, "c_after_barrier_grant");
        ex(b+10, 2, 32'h0002, "c_after_barrier_message");
        ex(b+13, 3, 1, "c_last_done");
        ex(b+13, 4, 2, "c_last_done_id");
        set_req(0, 1'b1, 1'b0, 16'h0001);
        step();
        set_req(0, 1'b0, 1'b0, 16'h0001);
        set_req(1, 1'b1, 1'b1, 16'hBEEF);
        set_req(2, 1'b1, 1'b0, 16'h0002);
        go(b+5);  set_req(1, 1'b0, 1'b0, 16'hBEEF);
        go(b+10); clear_reqs();
        go(b+16);

        // Wrap and skip
        do_reset();
        b = cyc;
        ex(b,   0, 32'h4, "d_setup_grant");
        ex(b+2, 0, 32'h1, "d_wrap_grant");
        ex(b+3, 0, 32'h4, "d_skip_grant");
        ex(b+3, 2, 32'h00D0, "d_wrap_message");
        ex(b+4, 2, 32'h00D2, "d_skip_message");
        ex(b+4, 1, 1, "d_skip_out_valid");
        ex(b+5, 0, 32'h8, "d_pointer_end");
        ex(b+6, 2, 32'h00E3, "d_pointer_message");
        set_req(2, 1'b1, 1'b0, 16'h0022);
        step();   clear_reqs();
        go(b+2);  set_req(0, 1'b1, 1'b0, 16'h00D0); set_req(2, 1'b1, 1'b0, 16'h00D2);
        go(b+4);  clear_reqs();
        go(b+5);  for (int i = 0; i < R; i++) set_req(i, 1'b1, 1'b0, 16'h00E0 + 16'(i));
        step();   clear_reqs();
        go(b+12);

        // Mid-flight reset
        do_reset();
        b = cyc;
        ex(b+2, 1, 1, "e_pre_reset_valid");
        ex(b+2, 2, 32'h0101, "e_pre_reset_message");
        ex(b+3, 1, 0, "e_reset_out_valid");
        ex(b+3, 2, 0, "e_reset_out_message");
        ex(b+3, 3, 0, "e_reset_done_valid");
        ex(b+3, 5, 0, "e_reset_busy");
        for (int k = 4; k <= 9; k++) ex(b+k, 3, 0, "e_no_stale_done");
        ex(b+6, 0, 32'h8, "e_post_grant");
        ex(b+7, 1, 1, "e_post_out_valid");
        ex(b+7, 2, 32'h0333, "e_post_message");
        ex(b+10, 3, 1, "e_post_done");
        ex(b+10, 4, 3, "e_post_done_id");
        set_req(0, 1'b1, 1'b0, 16'h0100);
        step(); clear_reqs(); set_req(1, 1'b1, 1'b0, 16'h0101);
        step(); clear_reqs(); set_req(2, 1'b1, 1'b0, 16'h0102);
        step(); clear_reqs(); rst = 1'b1;
        step(); rst = 1'b0;
        go(b+6); set_req(3, 1'b1, 1'b0, 16'h0333);
        step();  clear_reqs();
        go(b+14);

        // Zero tree latency, single requester, back-to-back barriers
        b = cyc;
        for (int k = 0; k < 4; k++) begin
            ex(b+3*k,   6, 1, "f_ready_issue");
            ex(b+3*k+1, 6, 0, "f_ready_drain1");
            ex(b+3*k+2, 6, 0, "f_ready_drain2");
            ex(b+3*k+1, 7, 1, "f_out_valid");
            ex(b+3*k+2, 7, 0, "f_out_valid_pulse");
            ex(b+3*k+1, 8, 0, "f_done_early");
            ex(b+3*k+2, 8, 1, "f_done_valid");
            ex(b+3*k+2, 9, 0, "f_done_id");
        end
        ex(b+1, 10, 32'h0B0B, "f_out_message");
        ex(b+2, 11, 1, "f_busy_at_done");
        ex(b+3, 11, 0, "f_busy_after_done");
        v1 = 1'b1; b1 = 1'b1; m1 = 16'h0B0B;
        go(b+12); v1 = 1'b0; b1 = 1'b0;
        go(b+16);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < R; i++) begin
                set_req(i, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 8),
                        16'($urandom));
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        clear_reqs();
        go(cyc + L + 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
